riscv_div_seq: RTL and testbench

//  Multi-cycle sequencer for the EX-stage ALU div/rem operators (ALU_DIVU, ALU_DIV, ALU_REMU, ALU_REM).

---
 rtl/riscv_div_seq_if.sv | 27 ++
 rtl/riscv_div_seq.sv | 121 ++++++++++++
 tb/tb_riscv_div_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_div_seq_if.sv
// riscv_div_seq_if: request/result handshake between the EX stage and the
// sequential divider.
// master = EX stage (drives request, kill, ex_ready); slave = divider (drives ready/valid/result).
interface riscv_div_seq_if #(
  parameter int WIDTH        = 32,
  parameter int ALU_OP_WIDTH = 6
);
  logic                    div_en_i;
  logic [ALU_OP_WIDTH-1:0] operator_i;
  logic [WIDTH-1:0]        op_a_i;
  logic [WIDTH-1:0]        op_b_i;
  logic                    kill_i;
  logic                    ex_ready_i;
  logic                    ready_o;
  logic                    valid_o;
  logic [WIDTH-1:0]        result_o;

  modport master (
    output div_en_i, operator_i, op_a_i, op_b_i, kill_i, ex_ready_i,
    input  ready_o, valid_o, result_o
  );

  modport slave (
    input  div_en_i, operator_i, op_a_i, op_b_i, kill_i, ex_ready_i,
    output ready_o, valid_o, result_o
  );
endinterface

// File: rtl/riscv_div_seq.sv
// riscv_div_seq: multi-cycle DIVU/DIV/REMU/REM unit beside the EX-stage ALU.
// Ports: clk, rst (sync, active-high), bus (slave side of riscv_div_seq_if).
// Latency: WIDTH+3 cycles from accept to valid (2 for divide-by-zero); the result is held until ex_ready_i.
module riscv_div_seq #(
  parameter int WIDTH        = 32,
  parameter int ALU_OP_WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  riscv_div_seq_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, PREP, DIVIDE, FIXUP, DONE} state_t;

  state_t           state;
  logic             is_signed;
  logic             is_rem;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] result;
  logic [5:0]       cnt;

  logic             op_is_div;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_diff;

  // Operator group 4'b1100 in the upper bits selects the div/rem family.
  assign op_is_div = (bus.operator_i[5:2] == 4'b1100);

  assign a_abs = (is_signed && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
  assign b_abs = (is_signed && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;

  // Shifted partial remainder needs WIDTH+1 bits so the compare cannot wrap;
  // whenever it is >= divisor the difference is < divisor and fits in WIDTH bits.
  assign rem_sh   = {rem, q[WIDTH-1]};
  assign rem_ge   = (rem_sh >= {1'b0, divisor});
  assign rem_diff = rem_sh[WIDTH-1:0] - divisor;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      is_signed <= 1'b0;
      is_rem    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      q         <= '0;
      rem       <= '0;
      divisor   <= '0;
      result    <= '0;
      cnt       <= '0;
    end else if (bus.kill_i) begin
      // Flush: drop whatever is in flight, result register keeps its value.
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.div_en_i && op_is_div) begin
            is_signed <= bus.operator_i[0];
            is_rem    <= bus.operator_i[1];
            a_q       <= bus.op_a_i;
            b_q       <= bus.op_b_i;
            state     <= PREP;
          end
        end
        PREP: begin
          neg_q   <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_r   <= is_signed & a_q[WIDTH-1];
          q       <= a_abs;
          divisor <= b_abs;
          rem     <= '0;
          cnt     <= 6'(WIDTH - 1);
          if (b_q == '0) begin
            // RISC-V divide-by-zero: quotient all ones, remainder = dividend.
            result <= is_rem ? a_q : '1;
            state  <= DONE;
          end else begin
            state  <= DIVIDE;
          end
        end
        DIVIDE: begin
          q   <= {q[WIDTH-2:0], rem_ge};
          rem <= rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
          if (cnt == 6'd0) begin
            state <= FIXUP;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        FIXUP: begin
          if (is_rem) begin
            result <= neg_r ? (~rem + 1'b1) : rem;
          end else begin
            result <= neg_q ? (~q + 1'b1) : q;
          end
          state <= DONE;
        end
        DONE: begin
          if (bus.ex_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready_o  = (state == IDLE);
  assign bus.valid_o  = (state == DONE);
  assign bus.result_o = result;

endmodule

// File: tb/tb_riscv_div_seq.sv
// tb_riscv_div_seq: scoreboard bench for riscv_div_seq.
// Stimulus pushes expected result/latency into a queue; a negedge monitor pops on valid&&ex_ready.
// Directed RISC-V corner cases, hold/back-to-back, kill/reset aborts, then random traffic vs a reference model.
module tb_riscv_div_seq;
  localparam int W = 32;
  localparam logic [5:0] OP_DIVU = 6'b110000;
  localparam logic [5:0] OP_DIV  = 6'b110001;
  localparam logic [5:0] OP_REMU = 6'b110010;
  localparam logic [5:0] OP_REM  = 6'b110011;
  localparam logic [5:0] OP_ADD  = 6'b000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_div_seq_if #(.WIDTH(W), .ALU_OP_WIDTH(6)) bus ();
  riscv_div_seq #(.WIDTH(W), .ALU_OP_WIDTH(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: RISC-V M-extension semantics in plain arithmetic.
  function automatic logic [W-1:0] ref_model(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic sgn;
    logic rm;
    sgn = op[0];
    rm  = op[1];
    if (b == 0) return rm ? a : {W{1'b1}};
    if (!sgn) return rm ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rm ? 32'h0 : 32'h8000_0000;
    return rm ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
  endfunction

  // Monitor: latency on the rising edge of valid, result on consumption.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.valid_o && !prev_valid) begin
        if (sb.size() == 0) check("unexpected_valid", 32'(bus.valid_o), 32'd0);
        else check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
      end
      if (bus.valid_o && bus.ex_ready_i && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("result", bus.result_o, e.res);
      end
      prev_valid = bus.valid_o;
    end
  end

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input bit push);
    int g;
    g = 0;
    while (!bus.ready_o && g < 200) begin step(); g++; end
    if (!bus.ready_o) check("ready_timeout", 32'(bus.ready_o), 32'd1);
    bus.div_en_i   = 1'b1;
    bus.operator_i = op;
    bus.op_a_i     = a;
    bus.op_b_i     = b;
    if (push) sb.push_back('{res: exp, lat: (b == 0) ? 2 : 35, acc: cyc});
    step();
    // Scramble inputs after acceptance; the DUT must use the latched copy.
    bus.div_en_i   = 1'b0;
    bus.operator_i = 6'($urandom);
    bus.op_a_i     = $urandom;
    bus.op_b_i     = $urandom;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (sb.size() > 0 && g < 100) begin step(); g++; end
    if (sb.size() > 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic abort_test(input bit use_rst);
    int acc;
    do_req(OP_DIVU, 32'd100, 32'd7, 32'd0, 1'b0);
    acc = cyc - 1;
    while (cyc < acc + 10) step();
    if (use_rst) rst = 1'b1; else bus.kill_i = 1'b1;
    step();
    rst = 1'b0;
    bus.kill_i = 1'b0;
    check(use_rst ? "rst_abort_ready" : "kill_abort_ready", 32'(bus.ready_o), 32'd1);
    check(use_rst ? "rst_abort_valid" : "kill_abort_valid", 32'(bus.valid_o), 32'd0);
    if (use_rst) check("rst_abort_result", bus.result_o, 32'd0);
    repeat (40) step();
    do_req(OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b1);
    wait_drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected under 100000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held;
    int g;
    bus.div_en_i   = 1'b0;
    bus.operator_i = '0;
    bus.op_a_i     = '0;
    bus.op_b_i     = '0;
    bus.kill_i     = 1'b0;
    bus.ex_ready_i = 1'b1;
    rst = 1'b1;
    repeat (3) step();
    check("reset_ready", 32'(bus.ready_o), 32'd1);
    check("reset_valid", 32'(bus.valid_o), 32'd0);
    check("reset_result", bus.result_o, 32'd0);
    rst = 1'b0;
    step();

    // Directed RISC-V cases with hand-derived expectations.
    do_req(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);                    wait_drain();
    do_req(OP_REMU, 32'd100, 32'd7, 32'd2, 1'b1);                     wait_drain();
    do_req(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);       wait_drain();
    do_req(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);       wait_drain();
    do_req(OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1'b1);       wait_drain();
    do_req(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);               wait_drain();
    do_req(OP_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1);       wait_drain();
    do_req(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1); wait_drain();
    do_req(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);       wait_drain();

    // Hold the result in DONE, then release and issue back-to-back.
    bus.ex_ready_i = 1'b0;
    do_req(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
    g = 0;
    while (!bus.valid_o && g < 100) begin step(); g++; end
    held = 32'd14;
    repeat (5) begin
      step();
      check("hold_valid", 32'(bus.valid_o), 32'd1);
      check("hold_result", bus.result_o, held);
    end
    bus.ex_ready_i = 1'b1;
    step();
    check("release_ready", 32'(bus.ready_o), 32'd1);
    check("release_valid", 32'(bus.valid_o), 32'd0);
    do_req(OP_REMU, 32'd100, 32'd7, 32'd2, 1'b1);
    wait_drain();

    // Aborts by kill and by reset.
    abort_test(1'b0);
    abort_test(1'b1);

    // Non-div operator is ignored.
    bus.div_en_i   = 1'b1;
    bus.operator_i = OP_ADD;
    bus.op_a_i     = 32'd1;
    bus.op_b_i     = 32'd1;
    step();
    bus.div_en_i = 1'b0;
    check("alu_add_ready", 32'(bus.ready_o), 32'd1);
    repeat (3) step();
    check("alu_add_valid", 32'(bus.valid_o), 32'd0);

    // kill in IDLE blocks a same-cycle request.
    bus.div_en_i   = 1'b1;
    bus.operator_i = OP_DIVU;
    bus.kill_i     = 1'b1;
    step();
    bus.div_en_i = 1'b0;
    bus.kill_i   = 1'b0;
    check("kill_idle_ready", 32'(bus.ready_o), 32'd1);
    repeat (3) step();

    // Random traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [5:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      case ($urandom_range(0, 3))
        0: op = OP_DIVU;
        1: op = OP_DIV;
        2: op = OP_REMU;
        default: op = OP_REM;
      endcase
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      do_req(op, a, b, ref_model(op, a, b), 1'b1);
      wait_drain();
    end

    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
